// File: rtl/polara_loopback_pkg.sv
// rtl/polara_loopback_pkg.sv - shared header field positions, message types and FSM states for the loopback checker
package polara_loopback_pkg;

  localparam int HDR_CHIPID_MSB = 63;
  localparam int HDR_CHIPID_LSB = 50;
  localparam int HDR_X_MSB      = 49;
  localparam int HDR_X_LSB      = 42;
  localparam int HDR_Y_MSB      = 41;
  localparam int HDR_Y_LSB      = 34;
  localparam int HDR_FBITS_MSB  = 33;
  localparam int HDR_FBITS_LSB  = 30;
  localparam int HDR_LEN_MSB    = 29;
  localparam int HDR_LEN_LSB    = 22;
  localparam int HDR_TYPE_MSB   = 21;
  localparam int HDR_TYPE_LSB   = 14;
  localparam int HDR_MSHR_MSB   = 13;
  localparam int HDR_MSHR_LSB   = 6;

  localparam logic [7:0] MSG_TYPE_INV_FWD    = 8'd16;
  localparam logic [7:0] MSG_TYPE_INV_FWDACK = 8'd17;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_HDR     = 2'b01,
    S_PAYLOAD = 2'b10
  } lb_state_e;

endpackage

// File: rtl/polara_lb_idle_timer.sv
// rtl/polara_lb_idle_timer.sv - counts idle cycles while enabled; sticky expired flag after TIMEOUT_CYCLES
module polara_lb_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic chipset_clk,
  input  logic chipset_rst_n,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  // While enabled, a cycle without tick means activity and restarts the count.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      if (!tick) begin
        count_q <= '0;
      end else if (count_q == LAST) begin
        expired <= 1'b1;
      end else begin
        count_q <= count_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/polara_loopback_rsp_checker.sv
// rtl/polara_loopback_rsp_checker.sv - always-ready NoC sink that decodes loopback responses and tracks pass/fail status
module polara_loopback_rsp_checker
  import polara_loopback_pkg::*;
#(
  parameter int          DATA_WIDTH     = 64,
  parameter logic [7:0]  EXP_MSG_TYPE   = MSG_TYPE_INV_FWDACK,
  parameter logic [15:0] EXP_PKTS       = 16'd1,
  parameter logic [7:0]  MAX_PAYLOAD    = 8'd8,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  chipset_clk,
  input  logic                  chipset_rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_val,
  output logic                  in_rdy,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count,
  output logic [DATA_WIDTH-1:0] last_hdr,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout
);

  lb_state_e   state_q, state_d;
  logic [7:0]  remaining_q;
  logic        accept, hdr_accept, pay_accept;
  logic [7:0]  hdr_len, hdr_type;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] pkt_next, err_next;

  assign in_rdy = (state_q != S_IDLE);
  // A flit alongside start belongs to the aborted session and is dropped.
  assign accept     = in_val & in_rdy & ~start;
  assign hdr_accept = accept & (state_q == S_HDR);
  assign pay_accept = accept & (state_q == S_PAYLOAD);

  assign hdr_len  = in_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_type = in_data[HDR_TYPE_MSB:HDR_TYPE_LSB];

  assign err_inc  = 2'(hdr_type != EXP_MSG_TYPE) + 2'(hdr_len > MAX_PAYLOAD) + 2'(done);
  assign err_sum  = {1'b0, err_count} + {15'd0, err_inc};
  assign err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  assign pkt_next = (pkt_count == 16'hFFFF) ? pkt_count : pkt_count + 16'd1;

  assign busy = in_rdy & ~done & ~timeout;
  assign pass = done & (err_count == 16'd0) & ~timeout;

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_HDR;
    end else begin
      case (state_q)
        S_HDR:     if (hdr_accept && hdr_len != 8'd0) state_d = S_PAYLOAD;
        S_PAYLOAD: if (pay_accept && remaining_q == 8'd1) state_d = S_HDR;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      pkt_count   <= '0;
      err_count   <= '0;
      last_hdr    <= '0;
      done        <= 1'b0;
      remaining_q <= '0;
    end else if (start) begin
      pkt_count   <= '0;
      err_count   <= '0;
      last_hdr    <= '0;
      done        <= 1'b0;
      remaining_q <= '0;
    end else if (hdr_accept) begin
      last_hdr    <= in_data;
      pkt_count   <= pkt_next;
      err_count   <= err_next;
      remaining_q <= hdr_len;
      if (pkt_next == EXP_PKTS) done <= 1'b1;
    end else if (pay_accept) begin
      remaining_q <= remaining_q - 8'd1;
    end
  end

  polara_lb_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .chipset_clk  (chipset_clk),
    .chipset_rst_n(chipset_rst_n),
    .clear        (start),
    .enable       (busy),
    .tick         (~accept),
    .expired      (timeout)
  );

endmodule

// File: tb/tb_polara_loopback_rsp_checker.sv
// tb/tb_polara_loopback_rsp_checker.sv - scoreboard bench for the loopback response checker
module tb_polara_loopback_rsp_checker;

  logic        chipset_clk = 1'b0;
  logic        chipset_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [15:0] pkt_count, err_count;
  logic [63:0] last_hdr;
  logic        busy, done, pass, timeout;

  always #5 chipset_clk = ~chipset_clk;

  polara_loopback_rsp_checker #(
    .DATA_WIDTH    (64),
    .EXP_MSG_TYPE  (8'd17),
    .EXP_PKTS      (16'd2),
    .MAX_PAYLOAD   (8'd8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .chipset_clk  (chipset_clk),
    .chipset_rst_n(chipset_rst_n),
    .start        (start),
    .in_data      (in_data),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .pkt_count    (pkt_count),
    .err_count    (err_count),
    .last_hdr     (last_hdr),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout)
  );

  typedef struct {
    logic [15:0] pkt;
    logic [15:0] err;
    logic [63:0] hdr;
    logic        done;
    logic        pass;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] prev_pkt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [13:0] chipid, input logic [7:0] len,
                                         input logic [7:0] typ, input logic [7:0] mshr);
    return {chipid, 8'd1, 8'd2, 4'd0, len, typ, mshr, 6'd0};
  endfunction

  task automatic expect_hdr(input logic [15:0] p, input logic [15:0] e, input logic [63:0] h,
                            input logic d, input logic ps);
    exp_t x;
    x.pkt = p; x.err = e; x.hdr = h; x.done = d; x.pass = ps;
    exp_q.push_back(x);
  endtask

  // Monitor: every header acceptance shows up as a nonzero change of pkt_count.
  always @(negedge chipset_clk) begin
    if (pkt_count != prev_pkt && pkt_count != 16'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_hdr", {48'd0, pkt_count}, 64'd0);
      end else begin
        check("sb_pkt_count", {48'd0, pkt_count}, {48'd0, exp_q[0].pkt});
        check("sb_err_count", {48'd0, err_count}, {48'd0, exp_q[0].err});
        check("sb_last_hdr", last_hdr, exp_q[0].hdr);
        check("sb_done", {63'd0, done}, {63'd0, exp_q[0].done});
        check("sb_pass", {63'd0, pass}, {63'd0, exp_q[0].pass});
        void'(exp_q.pop_front());
      end
    end
    prev_pkt <= pkt_count;
  end

  task automatic send(input logic [63:0] d);
    int n;
    n = 0;
    in_data = d;
    in_val  = 1'b1;
    @(negedge chipset_clk);
    while (!in_rdy && n < 40) begin
      @(negedge chipset_clk);
      n++;
    end
    check("flit_rdy", {63'd0, in_rdy}, 64'd1);
    @(posedge chipset_clk);
    #1;
    in_val = 1'b0;
  endtask

  task automatic idle();
    @(posedge chipset_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge chipset_clk);
    #1;
    start = 1'b0;
  endtask

  logic [63:0] h;

  initial begin
    repeat (3) @(posedge chipset_clk);
    #1;
    check("rst_in_rdy", {63'd0, in_rdy}, 64'd0);
    check("rst_pkt", {48'd0, pkt_count}, 64'd0);
    check("rst_err", {48'd0, err_count}, 64'd0);
    check("rst_last_hdr", last_hdr, 64'd0);
    check("rst_flags", {60'd0, busy, done, pass, timeout}, 64'd0);
    chipset_rst_n = 1'b1;
    idle();
    check("idle_in_rdy", {63'd0, in_rdy}, 64'd0);

    // Two back-to-back headers, then payload drained with gaps, then one extra header.
    do_start();
    check("armed_busy", {63'd0, busy}, 64'd1);
    check("armed_in_rdy", {63'd0, in_rdy}, 64'd1);
    h = mk_hdr(14'd0, 8'd0, 8'd17, 8'h11);
    expect_hdr(16'd1, 16'd0, h, 1'b0, 1'b0);
    send(h);
    h = mk_hdr(14'h2a5, 8'd3, 8'd17, 8'h22);
    expect_hdr(16'd2, 16'd0, h, 1'b1, 1'b1);
    send(h);
    for (int i = 0; i < 3; i++) begin
      send(64'hdead_0000 + 64'(i));
      idle();
    end
    check("t1_pass", {62'd0, done, pass}, 64'd3);
    h = mk_hdr(14'd1, 8'd0, 8'd17, 8'h33);
    expect_hdr(16'd3, 16'd1, h, 1'b1, 1'b0);
    send(h);
    idle();
    check("extra_pass", {63'd0, pass}, 64'd0);

    do_start();
    check("clr_pkt", {48'd0, pkt_count}, 64'd0);
    check("clr_err", {48'd0, err_count}, 64'd0);
    check("clr_last_hdr", last_hdr, 64'd0);
    check("clr_flags", {60'd0, busy, done, pass, timeout}, 64'h8);

    // Double-error header, then a header at exactly MAX_PAYLOAD.
    h = mk_hdr(14'h3ff, 8'd9, 8'd16, 8'h5a);
    expect_hdr(16'd1, 16'd2, h, 1'b0, 1'b0);
    send(h);
    for (int i = 0; i < 9; i++) send(64'hbeef_0000 + 64'(i));
    h = mk_hdr(14'd7, 8'd8, 8'd17, 8'h01);
    expect_hdr(16'd2, 16'd2, h, 1'b1, 1'b0);
    send(h);
    for (int i = 0; i < 8; i++) send(64'hcafe_0000 + 64'(i));
    h = mk_hdr(14'd8, 8'd0, 8'd17, 8'h02);
    expect_hdr(16'd3, 16'd3, h, 1'b1, 1'b0);
    send(h);
    idle();
    check("t3_err", {48'd0, err_count}, 64'd3);

    // Timeout with no traffic.
    do_start();
    repeat (15) @(posedge chipset_clk);
    #1;
    check("to_before", {62'd0, busy, timeout}, 64'd2);
    idle();
    check("to_set", {63'd0, timeout}, 64'd1);
    check("to_flags", {61'd0, busy, done, pass}, 64'd0);
    check("to_in_rdy", {63'd0, in_rdy}, 64'd1);

    // Asynchronous reset with two payload flits outstanding.
    do_start();
    h = mk_hdr(14'd3, 8'd4, 8'd17, 8'h44);
    expect_hdr(16'd1, 16'd0, h, 1'b0, 1'b0);
    send(h);
    send(64'h1);
    send(64'h2);
    #2;
    chipset_rst_n = 1'b0;
    #1;
    check("arst_in_rdy", {63'd0, in_rdy}, 64'd0);
    check("arst_pkt", {48'd0, pkt_count}, 64'd0);
    check("arst_last_hdr", last_hdr, 64'd0);
    check("arst_flags", {60'd0, busy, done, pass, timeout}, 64'd0);
    #2;
    chipset_rst_n = 1'b1;
    repeat (3) idle();
    check("post_rst_idle", {62'd0, in_rdy, busy}, 64'd0);
    do_start();
    h = mk_hdr(14'd4, 8'd0, 8'd17, 8'h55);
    expect_hdr(16'd1, 16'd0, h, 1'b0, 1'b0);
    send(h);
    repeat (2) idle();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
